// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial N-bit adder/subtractor built around one AddSub1b cell,
// LSB first, with registered carry, overflow and zero flags at completion.

module AddSub1b (
    input  logic a,
    input  logic b,
    input  logic ctrl,
    input  logic ci,
    output logic s,
    output logic co
);
    logic bx;
    assign bx = b ^ ctrl;
    assign s  = a ^ bx ^ ci;
    assign co = (a & bx) | (a & ci) | (bx & ci);
endmodule

module serial_addsub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         Start,
    input  logic         Ctrl,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         Overflow,
    output logic         Zero,
    output logic         Busy,
    output logic         Done
);
    localparam int CW = $clog2(N);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [N-1:0] a_sh, b_sh, r_sh, res;
    logic ctrl_l, carry, cmsb, cs, cco, accept, last;
    AddSub1b u_cell (.a(a_sh[0]), .b(b_sh[0]), .ctrl(ctrl_l), .ci(carry), .s(cs), .co(cco));
    assign accept = Start && state != RUN;
    assign last   = cnt == CW'(N - 1);
    assign res    = {cs, (N-1)'(r_sh >> 1)};
    assign Busy   = state == RUN;
    assign Done   = state == DONE;
    always_comb begin
        state_n = state;
        state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            r_sh     <= '0;
            ctrl_l   <= 1'b0;
            carry    <= 1'b0;
            cmsb     <= 1'b0;
            cnt      <= '0;
            S        <= '0;
            Co       <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
        end else if (accept) begin
            a_sh   <= A;
            b_sh   <= B;
            ctrl_l <= Ctrl;
            carry  <= Ctrl;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            r_sh  <= res;
            carry <= cco;
            cnt   <= last ? '0 : cnt + CW'(1);
            // carry into the MSB position, needed for signed overflow
            if (cnt == CW'(N - 2)) cmsb <= cco;
            if (last) begin
                S        <= res;
                Co       <= cco;
                Overflow <= cmsb ^ cco;
                Zero     <= res == '0;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: scoreboard bench for serial_addsub at N=8.

module tb_serial_addsub;
    localparam int N = 8;
    typedef struct packed {
        logic [N-1:0] s;
        logic co;
        logic ov;
        logic z;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic Start = 1'b0;
    logic Ctrl = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [N-1:0] S;
    logic Co, Overflow, Zero, Busy, Done;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    serial_addsub #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Ctrl(Ctrl), .A(A), .B(B),
        .S(S), .Co(Co), .Overflow(Overflow), .Zero(Zero), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        logic [N:0] sum;
        exp_t e;
        sum  = c ? ({1'b0, a} + {1'b0, ~b} + 1) : ({1'b0, a} + {1'b0, b});
        e.s  = sum[N-1:0];
        e.co = sum[N];
        e.ov = c ? (a[N-1] != b[N-1] && e.s[N-1] != a[N-1]) : (a[N-1] == b[N-1] && e.s[N-1] != a[N-1]);
        e.z  = e.s == '0;
        return e;
    endfunction

    // Called right after a negedge; returns at the negedge following the accepting edge.
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        A = a;
        B = b;
        Ctrl = c;
        Start = 1'b1;
        sb.push_back(model(a, b, c));
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
        lat = 0;
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 4 * N; i++) begin
            if (Busy) busy_cnt++;
            @(negedge clk);
            lat++;
            if (Done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        tests++;
        if ({S, Co, Overflow, Zero, Busy, Done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %h exp 0", {S, Co, Overflow, Zero, Busy, Done});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        logic [N-1:0] av[3] = '{8'h35, 8'h7F, 8'hFF};
        logic [N-1:0] bv[3] = '{8'h4A, 8'h01, 8'h01};
        exp_t e;
        int lat, bc;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            start_op(av[i], bv[i], 1'b0);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || lat != N || bc != N) begin
                fails++;
                $display("FAIL add_latency[%0d] got lat=%0d busy=%0d ok=%0d exp %0d", i, lat, bc, ok, N);
            end
            tests++;
            if ({S, Co, Overflow, Zero} !== e) begin
                fails++;
                $display("FAIL add_result[%0d] got %h exp %h", i, {S, Co, Overflow, Zero}, e);
            end
            @(negedge clk);
            tests++;
            if (Done !== 1'b0 || Busy !== 1'b0) begin
                fails++;
                $display("FAIL add_done_pulse[%0d] got done=%b busy=%b exp 0", i, Done, Busy);
            end
        end
    endtask

    task automatic test_sub;
        logic [N-1:0] av[2] = '{8'h10, 8'h55};
        logic [N-1:0] bv[2] = '{8'h20, 8'h55};
        exp_t e;
        int lat, bc;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            start_op(av[i], bv[i], 1'b1);
            wait_done(lat, bc, ok);
            e = sb.pop_front();
            tests++;
            if (!ok || lat != N) begin
                fails++;
                $display("FAIL sub_latency[%0d] got %0d ok=%0d exp %0d", i, lat, ok, N);
            end
            tests++;
            if ({S, Co, Overflow, Zero} !== e) begin
                fails++;
                $display("FAIL sub_result[%0d] got %h exp %h", i, {S, Co, Overflow, Zero}, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int lat, bc;
        bit ok;
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || {S, Co, Overflow, Zero} !== e) begin
            fails++;
            $display("FAIL b2b_first got %h ok=%0d exp %h", {S, Co, Overflow, Zero}, ok, e);
        end
        start_op(8'h01, 8'h01, 1'b0);
        tests++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_gap got busy=%b done=%b exp busy=1 done=0", Busy, Done);
        end
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || lat != N || {S, Co, Overflow, Zero} !== e) begin
            fails++;
            $display("FAIL b2b_second got %h lat=%0d exp %h lat=%0d", {S, Co, Overflow, Zero}, lat, e, N);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int lat, bc, extra;
        bit ok;
        start_op(8'h03, 8'h04, 1'b0);
        repeat (2) @(negedge clk);
        A = 8'hFF;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        A = 8'h00;
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || lat != N - 3 || {S, Co, Overflow, Zero} !== e) begin
            fails++;
            $display("FAIL busy_ignore got %h lat=%0d exp %h lat=%0d", {S, Co, Overflow, Zero}, lat, e, N - 3);
        end
        extra = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (Done) extra++;
        end
        tests++;
        if (extra != 0 || sb.size() != 0) begin
            fails++;
            $display("FAIL busy_single_done got %0d extra pulses exp 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int lat, bc, seen;
        bit ok;
        start_op(8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({S, Co, Overflow, Zero, Busy, Done} !== '0) begin
            fails++;
            $display("FAIL reset_async got %h exp 0", {S, Co, Overflow, Zero, Busy, Done});
        end
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (Done || Busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_abort got %0d active cycles exp 0", seen);
        end
        start_op(8'h01, 8'h02, 1'b0);
        wait_done(lat, bc, ok);
        e = sb.pop_front();
        tests++;
        if (!ok || lat != N || {S, Co, Overflow, Zero} !== e || S !== 8'h03) begin
            fails++;
            $display("FAIL reset_recover got %h lat=%0d exp %h lat=%0d", {S, Co, Overflow, Zero}, lat, e, N);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_busy_ignore;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial N-bit adder/subtractor that sequences two latched operands LSB-first through a single instance of the team's 1-bit add/sub cell, AddSub1b.
- Holds the carry between bits in a flop and assembles the result in a shift register.
- Reports carry, signed overflow and zero at completion.
- Sits between the operand registers and the result bus as a low-area alternative to the parallel ripple adder.

Parameters:
- N, 8, operand/result width in bits; legal range N >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request pulse or level; sampled only when not Busy.
- Ctrl  input  1  0 = add (A+B), 1 = subtract (A-B); latched with the operands.
- A  input  N  first operand; latched on an accepted Start.
- B  input  N  second operand; latched on an accepted Start.
- S  output  N  result register; valid while Done=1 and held until the next accepted Start.
- Co  output  1  final carry out. For subtract, 1 = no borrow (A >= B unsigned).
- Overflow  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- Zero  output  1  1 when S == 0; registered together with S.
- Busy  output  1  1 while in RUN.
- Done  output  1  one-cycle pulse when S/Co/Overflow/Zero become valid.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, carry=0, internal A/B shift registers=0.
  - All outputs are 0: S, Co, Overflow, Zero, Busy, Done.
  - Reset mid-RUN aborts the operation with no Done pulse. After release, the block waits in IDLE for a new Start.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with Start=1 at edge k (accepted):
  - A, B and Ctrl load into internal shift registers; carry flop loads Ctrl (+1 for two's-complement subtract); counter=0.
  - State goes to RUN; Busy=1 from edge k.
  - S, Co, Overflow and Zero keep their previous values until completion.
- RUN, each edge:
  - The AddSub1b instance receives A_sh[0], B_sh[0], Ctrl_latched, carry.
  - Its S bit shifts into the MSB of the result shift register, which shifts right.
  - carry <= Co of the cell; A_sh and B_sh shift right; counter increments.
  - On the bit with counter == N-2 the carry out is saved as carry-into-MSB.
- RUN with counter == N-1 (edge k+N):
  - The final bit is shifted in; S <= the complete result; Co <= cell Co.
  - Overflow <= saved carry-into-MSB XOR cell Co; Zero <= (complete result == 0).
  - State goes to DONE; Busy=0; Done=1 for exactly the following cycle.
- Latency: Done is high in the cycle after edge k+N, i.e. N cycles after the accepting edge.
- DONE, next edge:
  - Done drops to 0.
  - If Start=1, the operation is accepted (back-to-back) as in IDLE; otherwise the state goes to IDLE.
- Start while Busy=1 is ignored. Operand and Ctrl changes during RUN have no effect.
- Arithmetic is modulo 2^N. Co and Overflow follow the standard ripple adder definitions with B inverted and Ci=1 for subtract.
- The counter is $clog2(N) bits wide and never exceeds N-1.

Test Plan:
- N=8, add: Start, Ctrl=0, A=0x35, B=0x4A -> Done exactly 8 cycles after accept; S=0x7F, Co=0, Overflow=0, Zero=0; Busy high for 8 cycles.
- Add with overflow: A=0x7F, B=0x01, Ctrl=0 -> S=0x80, Co=0, Overflow=1. Then A=0xFF, B=0x01 -> S=0x00, Co=1, Overflow=0, Zero=1.
- Subtract: A=0x10, B=0x20, Ctrl=1 -> S=0xF0, Co=0 (borrow), Overflow=0. Then A=0x55, B=0x55 -> S=0x00, Co=1, Zero=1.
- Signed subtract overflow and back-to-back: A=0x80, B=0x01, Ctrl=1 -> S=0x7F, Overflow=1. Start held high through the DONE cycle with A=0x01, B=0x01, Ctrl=0 -> second Done 8 cycles later with S=0x02 and no idle gap.
- Start ignored while busy: accept A=0x03, B=0x04, Ctrl=0; pulse Start with A=0xFF at cycle 3 of RUN -> only one Done, S=0x07.
- Reset mid-operation: assert rst_n=0 at cycle 4 of RUN -> all outputs 0 immediately (asynchronous), no Done. After release, a new Start with A=0x01, B=0x02 -> S=0x03 after 8 cycles.
